// File: rtl/stress_rock_ctrl.sv
// stress_rock_ctrl: closed-loop rocking-intensity controller.
// Raises the rocking level while the heart rate is not dropping, lowers it
// while it keeps dropping, ends the session at level 0 and locks out on a
// sensor fault until the fault has been stable-released for a few ticks.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no session, level 0, waiting for start
// TRACK  | session active, level follows the heart-rate trend
// FAULT  | sensor error lockout, level 0, waiting for stable release
module stress_rock_ctrl #(
    parameter int START_LEVEL   = 4,
    parameter int MAX_LEVEL     = 7,
    parameter int CALM_TICKS    = 3,
    parameter int STRESS_TICKS  = 2,
    parameter int RELEASE_TICKS = 2
) (
    input  logic       clk12,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       stop,
    input  logic       gedaald,
    input  logic       err,
    input  logic       errRelease,
    output logic [2:0] level,
    output logic       rocking,
    output logic       fault,
    output logic       done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] TRACK = 2'd1;
    localparam logic [1:0] FAULT = 2'd2;

    localparam int CW = $clog2(CALM_TICKS + 1);
    localparam int SW = $clog2(STRESS_TICKS + 1);
    localparam int RW = $clog2(RELEASE_TICKS + 1);

    logic [1:0]    state;
    logic [CW-1:0] calm_cnt;
    logic [SW-1:0] stress_cnt;
    logic [RW-1:0] rel_cnt;

    logic [CW-1:0] calm_inc;
    logic [SW-1:0] stress_inc;
    logic [RW-1:0] rel_inc;

    // Counters are cleared as soon as they reach their threshold, so the
    // incremented value never exceeds the parameter and never wraps.
    assign calm_inc   = calm_cnt + CW'(1);
    assign stress_inc = stress_cnt + SW'(1);
    assign rel_inc    = rel_cnt + RW'(1);

    // Sequencing FSM; all outputs are registered alongside the state.
    always_ff @(posedge clk12) begin
        if (reset) begin
            state      <= IDLE;
            level      <= 3'd0;
            rocking    <= 1'b0;
            fault      <= 1'b0;
            done       <= 1'b0;
            calm_cnt   <= '0;
            stress_cnt <= '0;
            rel_cnt    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // A tick coinciding with start is deliberately not evaluated.
                    if (start) begin
                        state      <= TRACK;
                        level      <= 3'(START_LEVEL);
                        rocking    <= 1'b1;
                        calm_cnt   <= '0;
                        stress_cnt <= '0;
                    end
                end
                TRACK: begin
                    if (tick && err) begin
                        state      <= FAULT;
                        level      <= 3'd0;
                        rocking    <= 1'b0;
                        fault      <= 1'b1;
                        calm_cnt   <= '0;
                        stress_cnt <= '0;
                        rel_cnt    <= '0;
                    end else if (stop) begin
                        state      <= IDLE;
                        level      <= 3'd0;
                        rocking    <= 1'b0;
                        calm_cnt   <= '0;
                        stress_cnt <= '0;
                    end else if (tick && gedaald) begin
                        stress_cnt <= '0;
                        if (calm_inc == CW'(CALM_TICKS)) begin
                            calm_cnt <= '0;
                            if (level == 3'd1) begin
                                state   <= IDLE;
                                level   <= 3'd0;
                                rocking <= 1'b0;
                                done    <= 1'b1;
                            end else begin
                                level <= level - 3'd1;
                            end
                        end else begin
                            calm_cnt <= calm_inc;
                        end
                    end else if (tick) begin
                        calm_cnt <= '0;
                        if (stress_inc == SW'(STRESS_TICKS)) begin
                            stress_cnt <= '0;
                            if (level != 3'(MAX_LEVEL)) begin
                                level <= level + 3'd1;
                            end
                        end else begin
                            stress_cnt <= stress_inc;
                        end
                    end
                end
                FAULT: begin
                    // stop is ignored here; only a stable release leaves FAULT.
                    level <= 3'd0;
                    if (tick) begin
                        if (!err && errRelease) begin
                            if (rel_inc == RW'(RELEASE_TICKS)) begin
                                state   <= IDLE;
                                fault   <= 1'b0;
                                rel_cnt <= '0;
                            end else begin
                                rel_cnt <= rel_inc;
                            end
                        end else begin
                            rel_cnt <= '0;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    level      <= 3'd0;
                    rocking    <= 1'b0;
                    fault      <= 1'b0;
                    calm_cnt   <= '0;
                    stress_cnt <= '0;
                    rel_cnt    <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/stress_rock_ctrl.md
# stress_rock_ctrl

Closed-loop rocking-intensity controller for the rocking subsystem. It consumes the per-tick heart-rate trend flags from the heart-stress delta block (`gedaald`, `err`, `errRelease`). It raises the rocking level while the heart rate is not dropping and lowers it while the heart rate keeps dropping. It ends the session when the level reaches zero and locks out on a sensor fault until the fault is released. It sits between the heart-rate input stage and the motor-drive block.

## Interface
Parameters:
- `START_LEVEL`, default 4: level loaded on session start; must be in range 1..`MAX_LEVEL`.
- `MAX_LEVEL`, default 7: saturation ceiling for `level`; must be ≤ 7.
- `CALM_TICKS`, default 3: consecutive ticks with `gedaald`=1 needed for one level step down.
- `STRESS_TICKS`, default 2: consecutive ticks with `gedaald`=0 needed for one level step up.
- `RELEASE_TICKS`, default 2: consecutive qualifying ticks needed to leave FAULT.

Ports:
- `clk12`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `tick`  in  1  one-cycle strobe; heart-rate flags are valid and evaluated only when `tick`=1.
- `start`  in  1  request to begin a rocking session; level-sensitive, sampled every cycle.
- `stop`  in  1  request to abort the session immediately.
- `gedaald`  in  1  heart rate decreased since the last sample.
- `err`  in  1  heart-rate sensor error.
- `errRelease`  in  1  error condition stable and releasable.
- `level`  out  3  rocking intensity, 0..`MAX_LEVEL`.
- `rocking`  out  1  session active (state TRACK).
- `fault`  out  1  state FAULT.
- `done`  out  1  one-cycle pulse when a session ends by calming down to level 0.

## Operation
- States: IDLE, TRACK, FAULT. All outputs are registered.
- Reset: state IDLE; `level`=0; `rocking`=0, `fault`=0, `done`=0; all counters 0.
- IDLE:
  - If `start`=1: go to TRACK, load `level`=`START_LEVEL`, clear counters.
  - A `tick` in the same cycle is not evaluated.
  - `err` is ignored in IDLE.
- TRACK, priority highest first:
  1. `tick`=1 and `err`=1: go to FAULT; `level`=0; counters cleared.
  2. `stop`=1: go to IDLE; `level`=0; no `done` pulse.
  3. `tick`=1 and `gedaald`=1:
     - `stressCnt`=0 and `calmCnt`+1.
     - When `calmCnt` reaches `CALM_TICKS`: `level`−1 and `calmCnt`=0.
     - If `level` was 1: go to IDLE, `level`=0, `done`=1 for one cycle.
  4. `tick`=1 and `gedaald`=0:
     - `calmCnt`=0 and `stressCnt`+1.
     - When `stressCnt` reaches `STRESS_TICKS`: `level`+1, saturating at `MAX_LEVEL`, and `stressCnt`=0.
     - At saturation the counter still clears.
- `start` is ignored while in TRACK or FAULT.
- FAULT:
  - `level`=0 and `fault`=1.
  - On each `tick`: if `err`=0 and `errRelease`=1, `relCnt`+1; otherwise `relCnt`=0.
  - When `relCnt` reaches `RELEASE_TICKS`: go to IDLE, `fault`=0.
  - `stop` is ignored in FAULT; only release or `reset` exits.
- Counters are wide enough for their parameter value and never wrap.

## Timing
- All transitions occur on the `clk12` edge at which the triggering input is sampled. Outputs reflect the result in the following cycle, i.e. one cycle of latency.
- `done` is high for exactly one cycle and coincides with the first cycle of `level`=0 in IDLE.
- Cycles without `tick` hold all state and counters, except for `start` and `stop` handling.
- `reset` overrides everything, including mid-session and mid-FAULT. The block returns to the reset values one cycle later.
- A new session may start on the cycle after `done`.

## Test plan
- Reset, then `start` pulse → next cycle `level`=4 and `rocking`=1. Then 3 ticks with `gedaald`=1 → `level`=3 after the third tick.
- From `level`=1, 3 calm ticks → `level`=0, `rocking`=0, and `done` high for exactly one cycle.
- From `level`=6, 6 ticks with `gedaald`=0 → `level` goes 7, 7, 7, saturated. Alternating `gedaald` 1/0 every tick → `level` unchanged.
- In TRACK, a tick with `err`=1 → `fault`=1 and `level`=0. `stop` is then ignored. Two ticks with `err`=0 and `errRelease`=1 → IDLE. A non-qualifying tick in between restarts the count.
- `stop` and a `tick` with `err`=1 in the same cycle → FAULT. `stop` alone → IDLE with no `done`. `start` and `tick` together in IDLE → `level`=4, counters 0.
- `reset` asserted mid-TRACK at `level`=5 with `calmCnt`=2 → next cycle all outputs 0. A subsequent session needs a full 3 calm ticks to step down.
